// File: rtl/ticket_payment_ctrl.sv
// ----------------------------------------------------------------------------
// ticket_payment_ctrl
//   Coin/note collection controller for a ticket machine. A sale starts at the
//   price on fare, accepts coins until the price is covered, pulses
//   ticket_issue, then hands any change (or a full refund on cancel/timeout)
//   to the dispenser with a valid/ack handshake.
//
// Ports
//   clk           in   clock, rising edge
//   rd            in   asynchronous active-low reset
//   start         in   one-cycle request to begin a sale
//   fare[15:0]    in   price in Rs, latched on an accepted start
//   coin_valid    in   a coin/note is presented this cycle
//   coin_value    in   00=Rs1 01=Rs2 10=Rs5 11=Rs10
//   cancel        in   passenger abort (honoured in COLLECT only)
//   change_ack    in   dispenser took change_amount
//   busy          out  high outside IDLE
//   paid[15:0]    out  running amount inserted for the current sale
//   ticket_issue  out  one-cycle print pulse
//   change_valid  out  change_amount waiting for change_ack
//   change_amount out  Rs to return
//   refund        out  change_valid is a refund, not change
//   fare_err      out  one-cycle pulse after a start with fare==0
// ----------------------------------------------------------------------------
module ticket_payment_ctrl #(
    parameter int unsigned TIMEOUT = 200
) (
    input  logic        clk,
    input  logic        rd,
    input  logic        start,
    input  logic [15:0] fare,
    input  logic        coin_valid,
    input  logic [1:0]  coin_value,
    input  logic        cancel,
    input  logic        change_ack,
    output logic        busy,
    output logic [15:0] paid,
    output logic        ticket_issue,
    output logic        change_valid,
    output logic [15:0] change_amount,
    output logic        refund,
    output logic        fare_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_ISSUE,
        S_CHANGE,
        S_REFUND
    } state_t;

    localparam logic [8:0] TO_LIMIT = 9'(TIMEOUT);

    state_t      state_q, state_d;
    logic [15:0] fare_q, fare_d;
    logic [15:0] paid_q, paid_d;
    logic [15:0] chg_q, chg_d;
    logic [7:0]  tcnt_q, tcnt_d;
    logic        ferr_q, ferr_d;

    logic [3:0]  coin_amt;
    logic [16:0] paid_sum;
    logic [15:0] paid_add;
    logic [8:0]  tcnt_inc;

    always_comb begin
        unique case (coin_value)
            2'b00:   coin_amt = 4'd1;
            2'b01:   coin_amt = 4'd2;
            2'b10:   coin_amt = 4'd5;
            default: coin_amt = 4'd10;
        endcase
    end

    // Saturating add; a carry out of bit 15 pins the total at 16'hFFFF.
    assign paid_sum = {1'b0, paid_q} + {13'd0, coin_amt};
    assign paid_add = paid_sum[16] ? '1 : paid_sum[15:0];
    assign tcnt_inc = {1'b0, tcnt_q} + 9'd1;

    always_comb begin
        state_d = state_q;
        fare_d  = fare_q;
        paid_d  = paid_q;
        chg_d   = chg_q;
        tcnt_d  = tcnt_q;
        ferr_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (fare != '0) begin
                        fare_d  = fare;
                        paid_d  = '0;
                        tcnt_d  = '0;
                        chg_d   = '0;
                        state_d = S_COLLECT;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
            end
            S_COLLECT: begin
                if (coin_valid) begin
                    paid_d = paid_add;
                    tcnt_d = '0;
                end else begin
                    tcnt_d = tcnt_inc[7:0];
                end
                // Cancel outranks issue; the same-cycle coin is already in paid_d.
                if (cancel) begin
                    chg_d   = paid_d;
                    state_d = S_REFUND;
                end else if (coin_valid && (paid_add >= fare_q)) begin
                    state_d = S_ISSUE;
                end else if (!coin_valid && (tcnt_inc >= TO_LIMIT)) begin
                    chg_d   = paid_q;
                    state_d = S_REFUND;
                end
            end
            S_ISSUE: begin
                chg_d   = paid_q - fare_q;
                state_d = (paid_q != fare_q) ? S_CHANGE : S_IDLE;
            end
            S_CHANGE: begin
                if (change_ack) begin
                    chg_d   = '0;
                    state_d = S_IDLE;
                end
            end
            S_REFUND: begin
                if (paid_q == '0) begin
                    state_d = S_IDLE;
                end else if (change_ack) begin
                    chg_d   = '0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rd) begin
        if (!rd) begin
            state_q <= S_IDLE;
            fare_q  <= '0;
            paid_q  <= '0;
            chg_q   <= '0;
            tcnt_q  <= '0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            fare_q  <= fare_d;
            paid_q  <= paid_d;
            chg_q   <= chg_d;
            tcnt_q  <= tcnt_d;
            ferr_q  <= ferr_d;
        end
    end

    assign busy          = (state_q != S_IDLE);
    assign paid          = paid_q;
    assign ticket_issue  = (state_q == S_ISSUE);
    assign refund        = (state_q == S_REFUND) && (paid_q != '0);
    assign change_valid  = (state_q == S_CHANGE) || refund;
    assign change_amount = chg_q;
    assign fare_err      = ferr_q;

endmodule
